// File: rtl/adder_pkg.sv
// Shared types and helpers for the pipelined adder/subtractor.
// Operation encoding plus the signed-overflow rule used at the final stage.
package adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } adder_op_e;

    // Overflow when both effective operands share a sign and the result's sign differs.
    function automatic logic ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/adder_slice.sv
// One SW-bit ripple slice: sum and carry-out of a + b + cin.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module adder_slice #(
    parameter int SW = 16
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          cin,
    output logic [SW-1:0] sum,
    output logic          cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, cin};

endmodule

// File: rtl/pipe_adder.sv
// Pipelined add/sub: one SW-bit slice per stage, carry registered between stages.
// Latency: STAGES cycles from accept to out_valid when not stalled.
// Backpressure: global stall, in_ready = !out_valid || out_ready (combinational).
module pipe_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  adder_op_e        in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int SW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;
    localparam int MSB  = WIDTH - 1;

    if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_bad_cfg
        $error("pipe_adder: STAGES must be in 1..WIDTH and divide WIDTH");
    end

    // Per-stage inputs: operands, partial sum so far, incoming carry, valid.
    logic [STAGES-1:0][WIDTH-1:0] a_src;
    logic [STAGES-1:0][WIDTH-1:0] b_src;
    logic [STAGES-1:0][WIDTH-1:0] s_src;
    logic [STAGES-1:0]            c_src;
    logic [STAGES-1:0]            v_src;
    logic [STAGES-1:0][SW-1:0]    sl_sum;
    logic [STAGES-1:0]            sl_cout;

    logic             adv;
    logic             is_sub;
    logic             vld_q, vld_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cry_q, cry_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    assign adv      = !vld_q || out_ready;
    assign in_ready = adv;
    assign is_sub   = (in_op == OP_SUB);

    // SUB enters as A + ~B + 1, so later stages never need the opcode.
    assign a_src[0] = in_a;
    assign b_src[0] = is_sub ? ~in_b : in_b;
    assign s_src[0] = '0;
    assign c_src[0] = is_sub;
    assign v_src[0] = in_valid;

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        adder_slice #(
            .SW(SW)
        ) u_slice (
            .a    (SW'(a_src[k] >> (k * SW))),
            .b    (SW'(b_src[k] >> (k * SW))),
            .cin  (c_src[k]),
            .sum  (sl_sum[k]),
            .cout (sl_cout[k])
        );
    end

    if (STAGES > 1) begin : g_pipe
        logic [STAGES-2:0][WIDTH-1:0] a_q, a_d;
        logic [STAGES-2:0][WIDTH-1:0] b_q, b_d;
        logic [STAGES-2:0][WIDTH-1:0] s_q, s_d;
        logic [STAGES-2:0]            c_q, c_d;
        logic [STAGES-2:0]            v_q, v_d;

        always_comb begin
            a_d = '0;
            b_d = '0;
            s_d = '0;
            c_d = '0;
            v_d = '0;
            for (int k = 0; k < STAGES - 1; k++) begin
                a_d[k] = a_src[k];
                b_d[k] = b_src[k];
                s_d[k] = s_src[k] | (WIDTH'(sl_sum[k]) << (k * SW));
                c_d[k] = sl_cout[k];
                v_d[k] = v_src[k];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                a_q <= '0;
                b_q <= '0;
                s_q <= '0;
                c_q <= '0;
                v_q <= '0;
            end else if (adv) begin
                a_q <= a_d;
                b_q <= b_d;
                s_q <= s_d;
                c_q <= c_d;
                v_q <= v_d;
            end
        end

        for (genvar k = 1; k < STAGES; k++) begin : g_fwd
            assign a_src[k] = a_q[k-1];
            assign b_src[k] = b_q[k-1];
            assign s_src[k] = s_q[k-1];
            assign c_src[k] = c_q[k-1];
            assign v_src[k] = v_q[k-1];
        end
    end

    // Final stage completes the sum and registers the flags with it.
    always_comb begin
        sum_d  = s_src[LAST] | (WIDTH'(sl_sum[LAST]) << (LAST * SW));
        cry_d  = sl_cout[LAST];
        ovf_d  = ovf(a_src[LAST][MSB], b_src[LAST][MSB], sum_d[MSB]);
        zero_d = (sum_d == '0);
        vld_d  = v_src[LAST];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            sum_q  <= '0;
            cry_q  <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (adv) begin
            vld_q  <= vld_d;
            sum_q  <= sum_d;
            cry_q  <= cry_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign out_valid = vld_q;
    assign out_sum   = sum_q;
    assign out_carry = cry_q;
    assign out_ovf   = ovf_q;
    assign out_zero  = zero_q;

endmodule

// File: tb/tb_pipe_adder.sv
// Scoreboard bench for pipe_adder: four instances (STAGES 1,2,4,8), one selected at a time.
module tb_pipe_adder;
    import adder_pkg::*;

    localparam int W    = 32;
    localparam int NDUT = 4;
    localparam int NRND = 2500;

    typedef struct {
        adder_op_e   op;
        logic [31:0] a;
        logic [31:0] b;
        logic [34:0] e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tb_vld;
    adder_op_e   tb_op;
    logic [31:0] tb_a, tb_b;
    logic        tb_ordy;
    logic [1:0]  sel;

    logic        iv     [NDUT];
    logic        ordy   [NDUT];
    logic        i_rdy  [NDUT];
    logic        o_vld  [NDUT];
    logic [31:0] o_s    [NDUT];
    logic        o_c    [NDUT];
    logic        o_v    [NDUT];
    logic        o_z    [NDUT];

    logic        cur_vld, cur_rdy;
    logic [31:0] cur_s;
    logic [34:0] cur_res;

    logic [34:0] exp_q[$];
    int          acc_q[$];
    logic [34:0] pend;
    int          cyc = 0;
    int          nret = 0;
    bit          acc_hit;
    bit          chk_lat;
    logic        snap_rdy, snap_vld;
    logic [31:0] snap_sum;
    int          n_chk = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    vec_t        vecs[10];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        assign iv[g]   = tb_vld && (sel == 2'(g));
        assign ordy[g] = (sel == 2'(g)) ? tb_ordy : 1'b1;
        pipe_adder #(
            .WIDTH  (W),
            .STAGES (1 << g)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (iv[g]),
            .in_ready  (i_rdy[g]),
            .in_op     (tb_op),
            .in_a      (tb_a),
            .in_b      (tb_b),
            .out_valid (o_vld[g]),
            .out_ready (ordy[g]),
            .out_sum   (o_s[g]),
            .out_carry (o_c[g]),
            .out_ovf   (o_v[g]),
            .out_zero  (o_z[g])
        );
    end

    always_comb begin
        cur_vld = o_vld[sel];
        cur_rdy = i_rdy[sel];
        cur_s   = o_s[sel];
        cur_res = {o_s[sel], o_c[sel], o_v[sel], o_z[sel]};
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s (stages=%0d): observed 0x%0h expected 0x%0h", tag, 1 << sel, obs, exp);
        end
    endtask

    // Reference: plain 33-bit add of A and the effective B, flags from first principles.
    function automatic logic [34:0] model(input adder_op_e op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] be;
        logic [32:0] r;
        logic        v;
        be = (op == OP_SUB) ? ~b : b;
        r  = {1'b0, a} + {1'b0, be} + {32'd0, (op == OP_SUB)};
        v  = (a[31] == be[31]) && (r[31] != a[31]);
        return {r[31:0], r[32], v, (r[31:0] == 32'd0)};
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    // One clock: sample at negedge, retire before accept, then step past the rising edge.
    task automatic cycle();
        logic [34:0] e;
        int          t;
        @(negedge clk);
        acc_hit  = 0;
        snap_rdy = cur_rdy;
        snap_vld = cur_vld;
        snap_sum = cur_s;
        if (cur_vld && tb_ordy) begin
            nret++;
            chk("output_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                t = acc_q.pop_front();
                chk("result", 64'(cur_res), 64'(e));
                if (chk_lat) chk("latency", 64'(cyc + 1 - t), 64'(1 << sel));
            end
        end
        if (tb_vld && cur_rdy) begin
            exp_q.push_back(pend);
            acc_q.push_back(cyc + 1);
            acc_hit = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_one(input vec_t v);
        int n0;
        int k;
        n0     = nret;
        tb_op  = v.op;
        tb_a   = v.a;
        tb_b   = v.b;
        pend   = v.e;
        tb_vld = 1'b1;
        k = 0;
        do begin
            cycle();
            k++;
        end while (!acc_hit && k < 10);
        tb_vld = 1'b0;
        k = 0;
        while (nret == n0 && k < 20) begin
            cycle();
            k++;
        end
        chk("beats_retired", 64'(nret - n0), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n0;
        int          nxt;
        int          sent;
        int          budget;
        bit          stall;
        logic [31:0] held;

        vecs[0] = '{OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, {32'h0000_0000, 1'b1, 1'b0, 1'b1}};
        vecs[1] = '{OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, {32'h8000_0000, 1'b0, 1'b1, 1'b0}};
        vecs[2] = '{OP_SUB, 32'h8000_0000, 32'h0000_0001, {32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0}};
        vecs[3] = '{OP_SUB, 32'h0000_0005, 32'h0000_0007, {32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0}};
        vecs[4] = '{OP_SUB, 32'h0000_0007, 32'h0000_0005, {32'h0000_0002, 1'b1, 1'b0, 1'b0}};
        vecs[5] = '{OP_SUB, 32'h0000_0009, 32'h0000_0009, {32'h0000_0000, 1'b1, 1'b0, 1'b1}};
        vecs[6] = '{OP_ADD, 32'h0000_0000, 32'h0000_0000, {32'h0000_0000, 1'b0, 1'b0, 1'b1}};
        vecs[7] = '{OP_SUB, 32'h0000_0000, 32'h8000_0000, {32'h8000_0000, 1'b0, 1'b1, 1'b0}};
        vecs[8] = '{OP_ADD, 32'h8000_0000, 32'h8000_0000, {32'h0000_0000, 1'b1, 1'b1, 1'b1}};
        vecs[9] = '{OP_ADD, 32'h1234_5678, 32'h0FED_CBA9, {32'h2222_2221, 1'b0, 1'b0, 1'b0}};

        rst_n   = 1'b0;
        tb_vld  = 1'b0;
        tb_op   = OP_ADD;
        tb_a    = '0;
        tb_b    = '0;
        tb_ordy = 1'b1;
        sel     = 2'd0;
        chk_lat = 1'b0;
        pend    = '0;

        // Reset state of every instance.
        #12;
        for (int g = 0; g < NDUT; g++) begin
            sel = 2'(g);
            #1;
            chk("reset_out_valid", 64'(cur_vld), 64'd0);
            chk("reset_in_ready", 64'(cur_rdy), 64'd1);
            chk("reset_result_flags", 64'(cur_res), 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed corner vectors, each isolated so nominal latency can be checked.
        chk_lat = 1'b1;
        for (int g = 0; g < NDUT; g++) begin
            sel = 2'(g);
            foreach (vecs[i]) send_one(vecs[i]);
        end

        // STAGES=4: eight back-to-back beats with a 3-cycle output stall.
        sel     = 2'd2;
        chk_lat = 1'b0;
        n0      = nret;
        nxt     = 1;
        held    = '0;
        for (int c = 0; c < 60 && (nxt <= 8 || exp_q.size() != 0); c++) begin
            stall   = (c >= 6) && (c <= 8);
            tb_ordy = !stall;
            if (nxt <= 8) begin
                tb_op  = OP_ADD;
                tb_a   = 32'(nxt);
                tb_b   = 32'(nxt);
                pend   = {32'(2 * nxt), 1'b0, 1'b0, 1'b0};
                tb_vld = 1'b1;
            end else begin
                tb_vld = 1'b0;
            end
            cycle();
            if (acc_hit) nxt++;
            chk("stall_in_ready", 64'(snap_rdy), 64'(!stall));
            if (c == 6) held = snap_sum;
            if (c == 7 || c == 8) begin
                chk("stall_out_valid", 64'(snap_vld), 64'd1);
                chk("stall_hold_sum", 64'(snap_sum), 64'(held));
            end
        end
        tb_vld  = 1'b0;
        tb_ordy = 1'b1;
        chk("stall_beats_retired", 64'(nret - n0), 64'd8);

        // Reset with two beats in flight on STAGES=2.
        sel     = 2'd1;
        tb_op   = OP_ADD;
        tb_a    = 32'd10;
        tb_b    = 32'd20;
        pend    = model(OP_ADD, 32'd10, 32'd20);
        tb_vld  = 1'b1;
        cycle();
        tb_a    = 32'd30;
        tb_b    = 32'd40;
        pend    = model(OP_ADD, 32'd30, 32'd40);
        cycle();
        tb_vld  = 1'b0;
        chk("pre_reset_out_valid", 64'(cur_vld), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_out_valid", 64'(cur_vld), 64'd0);
        chk("async_reset_in_ready", 64'(cur_rdy), 64'd1);
        chk("async_reset_sum", 64'(cur_s), 64'd0);
        exp_q.delete();
        acc_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("post_reset_idle", 64'(snap_vld), 64'd0);
        end
        chk_lat = 1'b1;
        send_one('{OP_ADD, 32'd3, 32'd4, {32'd7, 1'b0, 1'b0, 1'b0}});

        // Random regression with random output backpressure on every depth.
        chk_lat = 1'b0;
        for (int g = 0; g < NDUT; g++) begin
            sel    = 2'(g);
            sent   = 0;
            budget = 0;
            while ((sent < NRND || exp_q.size() != 0) && budget < 8000) begin
                tb_ordy = ($urandom_range(0, 99) < 70);
                if (sent < NRND && $urandom_range(0, 99) < 80) begin
                    tb_op  = ($urandom_range(0, 1) == 1) ? OP_SUB : OP_ADD;
                    tb_a   = rnd_operand();
                    tb_b   = rnd_operand();
                    pend   = model(tb_op, tb_a, tb_b);
                    tb_vld = 1'b1;
                end else begin
                    tb_vld = 1'b0;
                end
                cycle();
                if (acc_hit) sent++;
                budget++;
            end
            tb_vld  = 1'b0;
            tb_ordy = 1'b1;
            chk("random_beats_sent", 64'(sent), 64'(NRND));
            chk("random_drained", 64'(exp_q.size()), 64'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pipe_adder.md
# pipe_adder

Parametrised, pipelined two's-complement adder/subtractor for the RISC-V datapath. It is the sequential successor to the single-cycle combinational `adder`. The operand width is split into `STAGES` equal slices, and the carry ripples through one pipeline register per slice, so one operation completes per cycle at higher clock rates. Valid/ready handshakes on both sides allow insertion between backpressuring pipeline stages. The block reports carry-out, signed overflow and zero flags alongside the result.

## Interface
Parameters:
- `WIDTH`, default 32: operand/result width in bits. Must be divisible by `STAGES`.
- `STAGES`, default 2: pipeline depth and slice count, range 1..`WIDTH`. Slice width `SW = WIDTH/STAGES`.

Ports:
- `clk`  in  1  rising-edge clock; the block's only clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `in_valid`  in  1  operand beat present.
- `in_ready`  out  1  block accepts the beat on this edge.
- `in_op`  in  `adder_op_e`  `OP_ADD` or `OP_SUB`.
- `in_a`  in  `WIDTH`  operand A.
- `in_b`  in  `WIDTH`  operand B.
- `out_valid`  out  1  result beat present.
- `out_ready`  in  1  consumer accepts the result beat.
- `out_sum`  out  `WIDTH`  result: A+B or A−B, modulo 2^WIDTH.
- `out_carry`  out  1  carry out of the MSB. For SUB this is 1 when no borrow occurs (A ≥ B unsigned).
- `out_ovf`  out  1  signed overflow.
- `out_zero`  out  1  `out_sum` is all zero.

## Operation
- SUB is computed as A + ~B + 1: B is inverted and the carry-in to slice 0 is 1. ADD uses carry-in 0.
- Stage k, for k = 0..STAGES−1:
  - adds slice k of A and B (bits [k·SW +: SW]) plus the carry registered by stage k−1;
  - registers its SW-bit partial sum, its carry, and the still-unconsumed upper slices of A and B.
- Lower-slice sums already produced travel with the beat, so the final stage holds the complete result.
- `out_ovf` = (A[MSB] == B'[MSB]) && (sum[MSB] != A[MSB]), where B' is the effective, post-inversion operand.
- `out_zero` is computed from the complete registered sum.
- Stall policy: a global advance signal, `adv = !out_valid || out_ready`.
  - When `adv` is 1, every stage loads from its predecessor.
  - When `adv` is 0, all stages hold.
  - Bubbles are not collapsed.
- `in_ready = adv`. This is a combinational path from `out_ready` to `in_ready`, by design.
- A beat is accepted on a rising edge when `in_valid && in_ready`. It is retired on a rising edge when `out_valid && out_ready`.
- Each stage carries a valid bit. A stage with valid 0 still shifts, but its data is don't-care.
- Output data is stable while `out_valid && !out_ready`.
- No beat is dropped or duplicated. Order is strictly FIFO.

## Timing
- Latency: a beat accepted at edge n appears on `out_valid` after edge n+STAGES, provided there are no stalls. Each stall cycle adds one.
- Throughput: one beat per cycle while `out_ready` = 1.
- `STAGES` = 1 degenerates to a single registered full-width adder with latency 1.
- Reset (`rst_n` low, asynchronous): all stage valid bits, `out_valid` and all data/flag registers clear to 0 immediately. `in_ready` is therefore 1 during and after reset.
- Reset mid-operation discards every in-flight beat. No partial result is emitted after release.
- Reset release is synchronised externally. The block samples normally from the first edge after `rst_n` goes high.
- Simultaneous accept and retire on the same edge is legal while `out_ready` = 1. The pipeline shifts one position.
- Wrap-around: results are modulo 2^WIDTH. Carry and overflow flags are the only indication.

## Structure
- Shared package `adder_pkg`:
  - `typedef enum logic {OP_ADD, OP_SUB} adder_op_e`;
  - helper function `ovf(a_msb, b_msb, s_msb)`.
- Sub-module `adder_slice`: purely combinational SW-bit add. Ports are `a`, `b`, `cin`, `sum` and `cout`. It is instantiated once per stage in a generate loop.
- Top-level `pipe_adder` contains the per-stage registers, the valid chain, the stall logic and flag generation.
- An elaboration-time check rejects `WIDTH % STAGES != 0`.

## Test plan
- WIDTH=32, STAGES=2, ADD 0xFFFFFFFF + 0x00000001 → `out_sum`=0x00000000, `out_carry`=1, `out_ovf`=0, `out_zero`=1, `out_valid` exactly 2 cycles after accept.
- ADD 0x7FFFFFFF + 0x00000001 → `out_sum`=0x80000000, `out_ovf`=1, `out_carry`=0. SUB 0x80000000 − 0x00000001 → 0x7FFFFFFF, `out_ovf`=1.
- SUB 5 − 7 → `out_sum`=0xFFFFFFFE, `out_carry`=0. SUB 7 − 5 → 0x00000002, `out_carry`=1. SUB 9 − 9 → `out_zero`=1, `out_carry`=1.
- STAGES=4 with back-to-back beats 1+1, 2+2 … 8+8, and `out_ready` low for 3 cycles mid-stream → results 2, 4 … 16 in order, none lost, `in_ready` low exactly during the stall, output data held stable.
- Assert `rst_n` low with 2 beats in flight → `out_valid`=0 immediately. After release no stale result appears, and the next beat 3+4 returns 7 with nominal latency.
- Random constrained regression across STAGES ∈ {1, 2, 4, 8} and random `out_ready` → scoreboard matches a reference A±B model with flags, 10k beats.
